// File: rtl/dcache_wb_unit.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU data port and block-wide RAM.
// Hit/miss counters are generated only when DCACHE_STATS_EN is defined; otherwise they read as zero.
module dcache_wb_unit #(
    parameter int OFFSET_WIDTH = 3,
    parameter int INDEX_WIDTH  = 6,
    parameter int ADDR_WIDTH   = 30,
    parameter int DATA_WIDTH   = 32,
    localparam int TAG_WIDTH   = ADDR_WIDTH - OFFSET_WIDTH - INDEX_WIDTH,
    localparam int BLOCK_WIDTH = DATA_WIDTH * (2 ** OFFSET_WIDTH),
    localparam int BE_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_read,
    input  logic                   cpu_write,
    input  logic [BE_WIDTH-1:0]    cpu_byte_w_en,
    input  logic [ADDR_WIDTH-1:0]  cpu_addr,
    input  logic [DATA_WIDTH-1:0]  cpu_wdata,
    input  logic                   ram_ready,
    input  logic [BLOCK_WIDTH-1:0] block_from_ram,
    output logic                   mem_stall,
    output logic [DATA_WIDTH-1:0]  cpu_rdata,
    output logic                   ram_en_out,
    output logic                   ram_write_out,
    output logic [ADDR_WIDTH-1:0]  ram_addr_out,
    output logic [BLOCK_WIDTH-1:0] block_to_ram,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
);
    localparam int LINES = 2 ** INDEX_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WB     = 2'd1,
        S_REFILL = 2'd2
    } state_t;

    state_t                  r_state;
    logic [BLOCK_WIDTH-1:0]  r_data [LINES];
    logic [TAG_WIDTH-1:0]    r_tag  [LINES];
    logic [LINES-1:0]        r_valid;
    logic [LINES-1:0]        r_dirty;
    logic [INDEX_WIDTH-1:0]  r_miss_idx;
    logic [TAG_WIDTH-1:0]    r_miss_tag;

    logic [TAG_WIDTH-1:0]    w_tag;
    logic [INDEX_WIDTH-1:0]  w_idx;
    logic [OFFSET_WIDTH-1:0] w_off;
    logic                    w_req;
    logic                    w_idle;
    logic                    w_hit;
    logic                    w_miss;
    logic                    w_write_hit;
    logic                    w_refill_done;
    logic [DATA_WIDTH-1:0]   w_word;
    logic [DATA_WIDTH-1:0]   w_merged;

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_w;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign {w_tag, w_idx, w_off} = cpu_addr;
    assign w_req         = cpu_read | cpu_write;
    assign w_idle        = (r_state == S_IDLE);
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss        = w_idle && w_req && !w_hit;
    // A zero byte-enable store on a hit must leave data and dirty untouched.
    assign w_write_hit   = w_idle && cpu_write && w_hit && (|cpu_byte_w_en);
    assign w_refill_done = (r_state == S_REFILL) && ram_ready;
    assign w_word        = r_data[w_idx][w_off*DATA_WIDTH +: DATA_WIDTH];
    assign w_merged      = merge_bytes(w_word, cpu_wdata, cpu_byte_w_en);

    // CPU and RAM side outputs decoded from the state and the current request.
    always_comb begin
        mem_stall     = 1'b0;
        cpu_rdata     = '0;
        ram_en_out    = 1'b0;
        ram_write_out = 1'b0;
        ram_addr_out  = '0;
        block_to_ram  = '0;
        case (r_state)
            S_IDLE: begin
                mem_stall = w_miss;
                if (cpu_read && w_hit) begin
                    cpu_rdata = w_word;
                end else begin
                    cpu_rdata = '0;
                end
            end
            S_WB: begin
                mem_stall     = 1'b1;
                ram_en_out    = 1'b1;
                ram_write_out = 1'b1;
                ram_addr_out  = {r_tag[r_miss_idx], r_miss_idx, {OFFSET_WIDTH{1'b0}}};
                block_to_ram  = r_data[r_miss_idx];
            end
            S_REFILL: begin
                mem_stall    = 1'b1;
                ram_en_out   = 1'b1;
                ram_addr_out = {r_miss_tag, r_miss_idx, {OFFSET_WIDTH{1'b0}}};
            end
            default: begin
                mem_stall = 1'b0;
            end
        endcase
    end

    // Miss FSM plus tag/valid/dirty bookkeeping; the miss line is latched so a dropped request still completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_dirty    <= '0;
            r_miss_idx <= '0;
            r_miss_tag <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_miss_idx <= w_idx;
                        r_miss_tag <= w_tag;
                        r_state    <= (r_valid[w_idx] && r_dirty[w_idx]) ? S_WB : S_REFILL;
                    end else if (w_write_hit) begin
                        r_dirty[w_idx] <= 1'b1;
                    end
                end
                S_WB: begin
                    if (ram_ready) begin
                        r_state <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (ram_ready) begin
                        r_tag[r_miss_idx]   <= r_miss_tag;
                        r_valid[r_miss_idx] <= 1'b1;
                        r_dirty[r_miss_idx] <= 1'b0;
                        r_state             <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Line data: whole-block refill, or a byte-merged store into one word on a hit.
    always_ff @(posedge clk) begin
        if (!rst && w_refill_done) begin
            r_data[r_miss_idx] <= block_from_ram;
        end else if (!rst && w_write_hit) begin
            r_data[w_idx][w_off*DATA_WIDTH +: DATA_WIDTH] <= w_merged;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;
    logic        r_after_refill;

    // The completion right after a refill belongs to the miss already counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count    <= 32'd0;
            r_miss_count   <= 32'd0;
            r_after_refill <= 1'b0;
        end else begin
            if (w_miss) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
            if (w_idle && w_req && w_hit && !r_after_refill) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            r_after_refill <= w_refill_done;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_wb_unit.sv
// Scoreboard bench for dcache_wb_unit: a behavioural RAM responder plus a word-level reference memory.
`timescale 1ns/1ps
module tb_dcache_wb_unit;
    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int BW  = DW * 8;
    localparam int BEW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_read;
    logic          cpu_write;
    logic [BEW-1:0] cpu_byte_w_en;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          ram_ready;
    logic [BW-1:0] block_from_ram;
    logic          mem_stall;
    logic [DW-1:0] cpu_rdata;
    logic          ram_en_out;
    logic          ram_write_out;
    logic [AW-1:0] ram_addr_out;
    logic [BW-1:0] block_to_ram;
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;

    always #5 clk = ~clk;

    dcache_wb_unit dut (
        .clk(clk), .rst(rst), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_byte_w_en(cpu_byte_w_en), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ram_ready(ram_ready), .block_from_ram(block_from_ram), .mem_stall(mem_stall),
        .cpu_rdata(cpu_rdata), .ram_en_out(ram_en_out), .ram_write_out(ram_write_out),
        .ram_addr_out(ram_addr_out), .block_to_ram(block_to_ram),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    int checks = 0;
    int failures = 0;
    int extra_delay = 0;
    int rcnt = 0;
    int unstable = 0;
    logic          prev_en = 1'b0;
    logic          prev_ready = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    logic [BW-1:0] ram_mem   [logic [AW-1:0]];
    logic [DW-1:0] model_mem [logic [AW-1:0]];

    typedef struct packed { logic [DW-1:0] rdata; int stalls; } exp_t;
    typedef struct packed { logic [AW-1:0] addr; logic wr; logic [DW-1:0] w5; } txn_t;
    exp_t sb_q[$];
    txn_t txn_q[$];

`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    function automatic logic [BW-1:0] ram_block(input logic [AW-1:0] ba);
        logic [BW-1:0] b;
        if (ram_mem.exists(ba)) return ram_mem[ba];
        for (int k = 0; k < 8; k++) b[k*DW +: DW] = {ba[27:0], 4'(k)};
        return b;
    endfunction

    function automatic logic [DW-1:0] model_word(input logic [AW-1:0] a);
        logic [BW-1:0] blk;
        if (model_mem.exists(a)) return model_mem[a];
        blk = ram_block({a[AW-1:3], 3'b000});
        return blk[a[2:0]*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] tb_merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                               input logic [BEW-1:0] be);
        logic [DW-1:0] r;
        r = o;
        for (int i = 0; i < BEW; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // RAM responder: answers after extra_delay waiting cycles and logs each completed transaction.
    always @(negedge clk) begin
        txn_t t;
        if (ram_en_out) begin
            if (prev_en && !prev_ready && ram_addr_out !== prev_addr) unstable++;
            if (rcnt >= extra_delay) begin
                ram_ready = 1'b1;
                rcnt = 0;
                if (ram_write_out) ram_mem[ram_addr_out] = block_to_ram;
                else block_from_ram = ram_block(ram_addr_out);
                t.addr = ram_addr_out;
                t.wr = ram_write_out;
                t.w5 = block_to_ram[5*DW +: DW];
                txn_q.push_back(t);
            end else begin
                ram_ready = 1'b0;
                rcnt++;
            end
        end else begin
            ram_ready = 1'b0;
            rcnt = 0;
        end
        prev_en = ram_en_out;
        prev_ready = ram_ready;
        prev_addr = ram_addr_out;
    end

    task automatic access(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [BEW-1:0] bev,
                          input int exp_stalls, input string nm);
        exp_t e;
        int stalls;
        bit done;
        logic [DW-1:0] old;
        logic [DW-1:0] got;
        old = model_word(a);
        e.rdata = rd ? old : '0;
        e.stalls = exp_stalls;
        sb_q.push_back(e);
        @(posedge clk); #1;
        cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = wd; cpu_byte_w_en = bev;
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (mem_stall) stalls++;
            else done = 1'b1;
        end
        got = cpu_rdata;
        e = sb_q.pop_front();
        checks++;
        if (!done || stalls != e.stalls) begin
            failures++;
            $display("FAIL %s stalls: got %0d (done=%0d) want %0d", nm, stalls, done, e.stalls);
        end
        checks++;
        if (got !== e.rdata) begin
            failures++;
            $display("FAIL %s rdata: got %h want %h", nm, got, e.rdata);
        end
        if (wr) model_mem[a] = tb_merge(old, wd, bev);
        @(posedge clk); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL reset mem_stall: got %b want 0", mem_stall); end
        checks++; if (ram_en_out !== 1'b0 || ram_write_out !== 1'b0) begin failures++; $display("FAIL reset ram_en/write: got %b%b want 00", ram_en_out, ram_write_out); end
        checks++; if (ram_addr_out !== '0) begin failures++; $display("FAIL reset ram_addr: got %h want 0", ram_addr_out); end
        checks++; if (block_to_ram !== '0) begin failures++; $display("FAIL reset block_to_ram: got nonzero want 0"); end
        checks++; if (cpu_rdata !== '0) begin failures++; $display("FAIL reset rdata: got %h want 0", cpu_rdata); end
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin failures++; $display("FAIL reset counters: got %0d/%0d want 0/0", hit_count, miss_count); end
    endtask

    task automatic test_read_miss();
        txn_q.delete();
        access(1'b1, 1'b0, 30'h105, 32'd0, 4'b0000, 2, "read_miss");
        checks++;
        if (txn_q.size() != 1 || txn_q[0].addr !== 30'h100 || txn_q[0].wr !== 1'b0) begin
            failures++; $display("FAIL read_miss txn: got %0d txns want one refill at 100", txn_q.size());
        end
        checks++;
        if (miss_count !== (STATS ? 32'd1 : 32'd0) || hit_count !== 32'd0) begin
            failures++; $display("FAIL read_miss counters: got hit=%0d miss=%0d", hit_count, miss_count);
        end
    endtask

    task automatic test_write_hit();
        access(1'b0, 1'b1, 30'h105, 32'h11223344, 4'b0011, 0, "write_hit");
        access(1'b1, 1'b0, 30'h105, 32'd0, 4'b0000, 0, "read_after_write");
        checks++;
        if (hit_count !== (STATS ? 32'd2 : 32'd0) || miss_count !== (STATS ? 32'd1 : 32'd0)) begin
            failures++; $display("FAIL write_hit counters: got hit=%0d miss=%0d", hit_count, miss_count);
        end
    endtask

    task automatic test_dirty_conflict();
        txn_q.delete();
        access(1'b1, 1'b0, 30'h505, 32'd0, 4'b0000, 3, "dirty_miss");
        checks++;
        if (txn_q.size() != 2) begin
            failures++; $display("FAIL dirty_miss txn count: got %0d want 2", txn_q.size());
        end else begin
            if (txn_q[0].addr !== 30'h100 || txn_q[0].wr !== 1'b1 || txn_q[0].w5 !== 32'hDEAD3344) begin
                failures++; $display("FAIL dirty_miss wb: got addr=%h wr=%b w5=%h want 100/1/DEAD3344", txn_q[0].addr, txn_q[0].wr, txn_q[0].w5);
            end
            checks++;
            if (txn_q[1].addr !== 30'h500 || txn_q[1].wr !== 1'b0) begin
                failures++; $display("FAIL dirty_miss refill: got addr=%h wr=%b want 500/0", txn_q[1].addr, txn_q[1].wr);
            end
        end
    endtask

    task automatic test_rw_both();
        access(1'b1, 1'b1, 30'h505, 32'hCAFEF00D, 4'b1111, 0, "rw_both");
        access(1'b1, 1'b0, 30'h505, 32'd0, 4'b0000, 0, "read_after_rw");
    endtask

    task automatic test_slow_refill();
        extra_delay = 4;
        unstable = 0;
        txn_q.delete();
        access(1'b1, 1'b0, 30'hA03, 32'd0, 4'b0000, 6, "slow_refill");
        checks++;
        if (unstable != 0 || txn_q.size() != 1 || txn_q[0].addr !== 30'hA00) begin
            failures++; $display("FAIL slow_refill ram side: unstable=%0d txns=%0d want 0/1 at A00", unstable, txn_q.size());
        end
        extra_delay = 0;
    endtask

    task automatic test_zero_be();
        access(1'b0, 1'b1, 30'hA03, 32'h12345678, 4'b0000, 0, "zero_be_write");
        access(1'b1, 1'b0, 30'hA03, 32'd0, 4'b0000, 0, "read_after_zero_be");
        access(1'b1, 1'b0, 30'hE03, 32'd0, 4'b0000, 2, "clean_victim_miss");
    endtask

    task automatic test_reset_mid_refill();
        extra_delay = 4;
        @(posedge clk); #1;
        cpu_read = 1'b1; cpu_addr = 30'hC11;
        @(negedge clk);
        checks++; if (mem_stall !== 1'b1) begin failures++; $display("FAIL rst_refill miss stall: got %b want 1", mem_stall); end
        @(negedge clk);
        checks++; if (ram_en_out !== 1'b1 || ram_write_out !== 1'b0 || ram_addr_out !== 30'hC10) begin
            failures++; $display("FAIL rst_refill refill: got en=%b wr=%b addr=%h want 1/0/C10", ram_en_out, ram_write_out, ram_addr_out);
        end
        @(negedge clk);
        rst = 1'b1;
        cpu_read = 1'b0;
        @(negedge clk);
        checks++; if (ram_en_out !== 1'b0 || mem_stall !== 1'b0 || ram_addr_out !== '0) begin
            failures++; $display("FAIL rst_refill abandon: got en=%b stall=%b addr=%h want 0/0/0", ram_en_out, mem_stall, ram_addr_out);
        end
        rst = 1'b0;
        extra_delay = 0;
        model_mem.delete();
        access(1'b1, 1'b0, 30'hC11, 32'd0, 4'b0000, 2, "reread_after_reset");
        checks++;
        if (miss_count !== (STATS ? 32'd1 : 32'd0) || hit_count !== 32'd0) begin
            failures++; $display("FAIL rst_refill counters: got hit=%0d miss=%0d", hit_count, miss_count);
        end
    endtask

    initial begin
        logic [BW-1:0] b;
        rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_byte_w_en = '0;
        cpu_addr = '0; cpu_wdata = '0; ram_ready = 1'b0; block_from_ram = '0;
        b = ram_block(30'h100);
        b[5*DW +: DW] = 32'hDEADBEEF;
        ram_mem[30'h100] = b;
        test_reset();
        test_read_miss();
        test_write_hit();
        test_dirty_conflict();
        test_rw_both();
        test_slow_refill();
        test_zero_be();
        test_reset_mid_refill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
